// File: rtl/swbox_cfg_pkg.sv
// Shared definitions for the switch-box configuration loader.
//   cfg_state_t : loader state (LOAD accepts frame words, DRAIN discards the
//                 rest of an over-long frame, COMMIT is the one-cycle
//                 shadow-to-active transfer).
//   SEL_ILLEGAL : the only 2-bit select code the switch box does not define.
//   nwords()    : number of WORD_W-bit words needed to carry W*8 config bits.
package swbox_cfg_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    function automatic int nwords(input int w, input int word_w);
        return (w * 8 + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/swbox_cfg_field_check.sv
// Combinational scan of a full configuration image for illegal select codes.
//   cfg     : CFG_W-bit configuration image (2-bit select fields, LSB first)
//   illegal : 1 when any 2-bit field equals SEL_ILLEGAL
module swbox_cfg_field_check
    import swbox_cfg_pkg::*;
#(
    parameter int CFG_W = 56
) (
    input  logic [CFG_W-1:0] cfg,
    output logic             illegal
);

    logic [CFG_W/2-1:0] field_bad;

    generate
        for (genvar gi = 0; gi < CFG_W / 2; gi++) begin : g_field
            assign field_bad[gi] = (cfg[2*gi +: 2] == SEL_ILLEGAL);
        end
    endgenerate

    assign illegal = |field_bad;

endmodule

// File: rtl/swbox_cfg_loader.sv
// Word-serial configuration loader for one universal_switch_box.
// Words of a frame are collected into a shadow image and copied to the
// active select bus c in a single cycle, so the switch box never sees a
// partially written configuration.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_data/cfg_last : word stream, first word = LSBs
//   cfg_abort   : synchronous abort, overrides everything else
//   c           : active select bus (CFG_W = W*8 bits), registered
//   cfg_done    : one-cycle pulse when a new configuration becomes active
//   cfg_err     : sticky short/long frame (or illegal code) error flag
//
// Build option: define SWBOX_CFG_CODE_CHECK_EN to refuse committing any
// image containing a 2'b11 select code.
module swbox_cfg_loader
    import swbox_cfg_pkg::*;
#(
    parameter int W      = 7,
    parameter int WORD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_last,
    input  logic                cfg_abort,
    output logic [W*8-1:0]      c,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int CFG_W  = W * 8;
    localparam int NWORDS = nwords(W, WORD_W);
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    cfg_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next;
    logic [CFG_W-1:0]  c_reg, c_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              load_we;
    logic [NWORDS-1:0] word_we;
    logic [CFG_W-1:0]  shadow;
    logic              code_illegal;
    logic              accept;

    assign cfg_ready = (state_reg != COMMIT);
    assign accept    = cfg_valid & cfg_ready;

    // Shadow image: one register slice per word. The final word's slice is
    // narrower when CFG_W is not a multiple of WORD_W, which drops the
    // surplus upper bits of that word.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            localparam int LO  = gi * WORD_W;
            localparam int WID = (CFG_W - LO < WORD_W) ? (CFG_W - LO) : WORD_W;

            logic [WID-1:0] part_reg;

            assign word_we[gi] = load_we & (word_cnt_reg == CNT_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    part_reg <= '0;
                end else if (word_we[gi]) begin
                    part_reg <= cfg_data[WID-1:0];
                end
            end

            assign shadow[LO +: WID] = part_reg;
        end
    endgenerate

`ifdef SWBOX_CFG_CODE_CHECK_EN
    swbox_cfg_field_check #(
        .CFG_W (CFG_W)
    ) u_field_check (
        .cfg     (shadow),
        .illegal (code_illegal)
    );
`else
    assign code_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOAD;
            word_cnt_reg <= '0;
            c_reg        <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            c_reg        <= c_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        c_next        = c_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        load_we       = 1'b0;

        if (cfg_abort) begin
            // Abort discards the frame in progress, including a pending
            // commit; the active image is left untouched.
            state_next    = LOAD;
            word_cnt_next = '0;
            err_next      = 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (accept) begin
                        load_we = 1'b1;
                        if (word_cnt_reg == LAST_IDX) begin
                            word_cnt_next = '0;
                            if (cfg_last) begin
                                state_next = COMMIT;
                            end else begin
                                err_next   = 1'b1;
                                state_next = DRAIN;
                            end
                        end else if (cfg_last) begin
                            err_next      = 1'b1;
                            word_cnt_next = '0;
                        end else begin
                            word_cnt_next = word_cnt_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && cfg_last) begin
                        state_next    = LOAD;
                        word_cnt_next = '0;
                    end
                end
                COMMIT: begin
                    state_next    = LOAD;
                    word_cnt_next = '0;
                    if (code_illegal) begin
                        err_next = 1'b1;
                    end else begin
                        c_next    = shadow;
                        done_next = 1'b1;
                        err_next  = 1'b0;
                    end
                end
                default: begin
                    state_next    = LOAD;
                    word_cnt_next = '0;
                end
            endcase
        end
    end

    assign c        = c_reg;
    assign cfg_done = done_reg;
    assign cfg_err  = err_reg;

endmodule

// File: tb/tb_swbox_cfg_loader.sv
// Bench for swbox_cfg_loader: a frame-level model (queue of received words)
// is compared with the DUT on every falling edge, plus directed literal
// checks and a second instance with 16-bit words.
module tb_swbox_cfg_loader;

    localparam int W      = 7;
    localparam int NW     = 7;
    localparam bit CHK_EN =
`ifdef SWBOX_CFG_CODE_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_data = '0;
    logic        cfg_last = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [55:0] c;
    logic        cfg_done;
    logic        cfg_err;

    logic        v16 = 1'b0;
    logic        rdy16;
    logic [15:0] d16 = '0;
    logic        l16 = 1'b0;
    logic [55:0] c16;
    logic        done16;
    logic        err16;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    swbox_cfg_loader #(.W(W), .WORD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_abort(cfg_abort),
        .c(c), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    swbox_cfg_loader #(.W(W), .WORD_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v16), .cfg_ready(rdy16),
        .cfg_data(d16), .cfg_last(l16), .cfg_abort(1'b0),
        .c(c16), .cfg_done(done16), .cfg_err(err16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (frame level) ----------------
    logic [55:0] m_c = '0;
    logic [55:0] m_frame = '0;
    bit          m_done = 0;
    bit          m_err = 0;
    bit          m_pend = 0;
    bit          m_drain = 0;
    logic [7:0]  m_q[$];

    function automatic bit has_code3(input logic [55:0] img);
        for (int j = 0; j < 28; j++)
            if (img[2*j +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_c = '0; m_done = 0; m_err = 0; m_pend = 0; m_drain = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (cfg_abort) begin
                m_pend = 0; m_drain = 0; m_err = 0;
                m_q.delete();
            end else if (m_pend) begin
                m_pend = 0;
                if (CHK_EN && has_code3(m_frame)) m_err = 1;
                else begin
                    m_c = m_frame; m_done = 1; m_err = 0;
                end
            end else if (cfg_valid) begin
                if (m_drain) begin
                    if (cfg_last) m_drain = 0;
                end else begin
                    m_q.push_back(cfg_data);
                    if (m_q.size() == NW) begin
                        if (cfg_last) begin
                            for (int i = 0; i < NW; i++) m_frame[i*8 +: 8] = m_q[i];
                            m_pend = 1;
                        end else begin
                            m_err = 1; m_drain = 1;
                        end
                        m_q.delete();
                    end else if (cfg_last) begin
                        m_err = 1;
                        m_q.delete();
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("c", c, m_c);
        chk("cfg_done", cfg_done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("cfg_ready", cfg_ready, !m_pend);
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send_word(input logic [7:0] d, input bit last);
        bit took = 0;
        bit rdy;
        int n = 0;
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        while (!took && n < 16) begin
            rdy = cfg_ready;
            @(negedge clk);
            took = rdy;
            n++;
        end
        if (!took) begin
            chk_cnt++;
            $display("FAIL ready_wait: word %h not accepted in %0d cycles, required acceptance", d, n);
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_abort();
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
    endtask

    function automatic logic [7:0] rand_word(input bit legal);
        logic [7:0] w;
        if (!legal) return 8'($urandom);
        for (int j = 0; j < 4; j++) w[2*j +: 2] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    task automatic send16(input logic [15:0] d, input bit last);
        bit took = 0;
        bit rdy;
        int n = 0;
        v16 = 1'b1; d16 = d; l16 = last;
        while (!took && n < 16) begin
            rdy = rdy16;
            @(negedge clk);
            took = rdy;
            n++;
        end
        if (!took) begin
            chk_cnt++;
            $display("FAIL ready16_wait: word %h not accepted in %0d cycles, required acceptance", d, n);
        end
        v16 = 1'b0; l16 = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [55:0] c_prev;
        logic [7:0]  good[NW];

        // Reset state
        idle(2);
        chk("rst_c", c, 56'h0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_ready", cfg_ready, 1'b1);

        // Frame 0x11..0x77: commit one edge after the last word
        for (int i = 0; i < NW; i++) send_word(8'((i + 1) * 8'h11), i == NW - 1);
        chk("f1_ready_commit", cfg_ready, 1'b0);
        chk("f1_done_early", cfg_done, 1'b0);
        idle(1);
        chk("f1_c", c, CHK_EN ? 56'h0 : 56'h77665544332211);
        chk("f1_done", cfg_done, !CHK_EN);
        chk("f1_err", cfg_err, CHK_EN);
        chk("f1_ready_back", cfg_ready, 1'b1);
        idle(1);
        chk("f1_done_1cyc", cfg_done, 1'b0);
        c_prev = CHK_EN ? 56'h0 : 56'h77665544332211;

        // Short frame, then a legal frame clears the error
        send_word(8'hA1, 0); send_word(8'hA2, 0); send_word(8'hA3, 1);
        chk("short_err", cfg_err, 1'b1);
        chk("short_c", c, c_prev);
        good = '{8'h12, 8'h21, 8'h22, 8'h10, 8'h01, 8'h20, 8'h02};
        for (int i = 0; i < NW; i++) send_word(good[i], i == NW - 1);
        idle(1);
        chk("good_c", c, 56'h02200110222112);
        chk("good_done", cfg_done, 1'b1);
        chk("good_err_clr", cfg_err, 1'b0);

        // Long frame: error after word 7, words 8 and 9 drained
        for (int i = 0; i < NW; i++) send_word(8'h80 + 8'(i), 0);
        chk("long_err", cfg_err, 1'b1);
        chk("long_ready", cfg_ready, 1'b1);
        send_word(8'h88, 0);
        send_word(8'h89, 1);
        chk("long_c", c, 56'h02200110222112);
        chk("long_err_sticky", cfg_err, 1'b1);

        // Abort in the COMMIT cycle
        for (int i = 0; i < NW; i++) send_word(8'h01, i == NW - 1);
        pulse_abort();
        chk("abort_done", cfg_done, 1'b0);
        chk("abort_c", c, 56'h02200110222112);
        chk("abort_err", cfg_err, 1'b0);
        for (int i = 0; i < NW; i++) begin
            idle($urandom_range(0, 2));
            send_word(8'h02, i == NW - 1);
        end
        idle(1);
        chk("after_abort_c", c, 56'h02020202020202);
        chk("after_abort_done", cfg_done, 1'b1);

        // Illegal code in c[3:2]
        for (int i = 0; i < NW; i++) send_word(i == 0 ? 8'h0C : 8'h00, i == NW - 1);
        idle(1);
        chk("code3_c", c, CHK_EN ? 56'h02020202020202 : 56'h0000000000000C);
        chk("code3_done", cfg_done, !CHK_EN);
        chk("code3_err", cfg_err, CHK_EN);

        // 16-bit words: top byte of the last word is discarded
        send16(16'hAAAA, 0); send16(16'hBBBB, 0); send16(16'hCCCC, 0); send16(16'hDDDD, 1);
        chk("w16_ready_commit", rdy16, 1'b0);
        idle(1);
        chk("w16_c", c16, CHK_EN ? 56'h0 : 56'hDDCCCCBBBBAAAA);
        chk("w16_done", done16, !CHK_EN);
        chk("w16_err", err16, CHK_EN);

        // Asynchronous reset mid-frame
        for (int i = 0; i < NW; i++) send_word(8'h11, i == NW - 1);
        idle(2);
        send_word(8'h05, 0); send_word(8'h06, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_c", c, 56'h0);
        chk("midrst_err", cfg_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Randomised frames with gaps, aborts, short and long frames
        for (int f = 0; f < 150; f++) begin
            int kind = $urandom_range(0, 9);
            int n = (kind < 6) ? NW : (kind < 8) ? $urandom_range(1, NW - 1) : $urandom_range(NW + 1, NW + 3);
            bit legal = $urandom_range(0, 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                if ($urandom_range(0, 24) == 0) pulse_abort();
                send_word(rand_word(legal), i == n - 1);
            end
            if (kind < 6 && $urandom_range(0, 4) == 0) pulse_abort();
        end
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
